// File: rtl/byte_sum_sequencer.sv
// Frame accumulator that sequences an external 8-bit adder through a low-byte
// pass and a high-byte pass per input byte, then presents the 16-bit frame total.
module byte_sum_sequencer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic [7:0]       add_a,
  output logic [7:0]       add_b,
  input  logic [7:0]       add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  typedef enum logic [1:0] {
    IDLE,
    ADD_LO,
    ADD_HI,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [15:0]      acc;
  logic             carry_r;
  logic [7:0]       byte_r;
  logic             last_r;
  logic [CNT_W-1:0] count;
  logic             ovf;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement leaves a signal unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    add_a     = 8'h00;
    add_b     = 8'h00;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ADD_LO;
      end
      ADD_LO: begin
        add_a     = acc[7:0];
        add_b     = byte_r;
        state_nxt = ADD_HI;
      end
      ADD_HI: begin
        add_a     = acc[15:8];
        add_b     = {7'b0, carry_r};
        state_nxt = last_r ? DONE : IDLE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: the adder result is captured on the edge that leaves each pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= 16'h0000;
      carry_r <= 1'b0;
      byte_r  <= 8'h00;
      last_r  <= 1'b0;
      count   <= '0;
      ovf     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            byte_r <= in_data;
            last_r <= in_last;
          end
        end
        ADD_LO: begin
          acc[7:0] <= add_sum;
          carry_r  <= add_cout;
        end
        ADD_HI: begin
          acc[15:8] <= add_sum;
          ovf       <= ovf | add_cout;
          if (count != '1) count <= count + 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            acc     <= 16'h0000;
            count   <= '0;
            ovf     <= 1'b0;
            carry_r <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_sum   = acc;
  assign out_count = count;
  assign out_ovf   = ovf;

endmodule

// File: tb/tb_byte_sum_sequencer.sv
// Directed bench for byte_sum_sequencer with a behavioural 8-bit adder on the
// operand port; frame tables plus cycle-exact sequences for stall and reset.
module tb_byte_sum_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic [7:0]  add_a;
  logic [7:0]  add_b;
  logic [7:0]  add_sum;
  logic        add_cout;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic [7:0]  out_count;
  logic        out_ovf;

  int n_cmp  = 0;
  int n_fail = 0;

  byte_sum_sequencer #(.CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  // Stand-in for the ripple-carry adder, carry-in tied to 0.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b};

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  32'(in_ready),  32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_add_a"},     32'(add_a),     32'd0);
    check({tag, "_add_b"},     32'(add_b),     32'd0);
    check({tag, "_out_sum"},   32'(out_sum),   32'd0);
    check({tag, "_out_count"}, 32'(out_count), 32'd0);
    check({tag, "_out_ovf"},   32'(out_ovf),   32'd0);
  endtask

  // Presents one byte and returns 1 time unit after the accepting edge.
  task automatic send_byte(input logic [7:0] d, input logic last);
    int t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 50) check("in_ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int waited);
    waited = 0;
    while (!out_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!out_valid) check("result_timeout", 32'(out_valid), 32'd1);
  endtask

  typedef struct {
    int              n;
    logic [3:0][7:0] b;
    logic [15:0]     sum;
    int              cnt;
    logic            ovf;
  } frame_t;

  typedef struct {
    logic        iv;
    logic [7:0]  d;
    logic        l;
    logic        rdy;
    logic        ov;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] sum;
    logic [7:0]  cnt;
  } step_t;

  frame_t frames [6];
  step_t  steps  [12];

  initial begin
    int waited;

    frames[0] = '{n:1, b:32'h0000_0005, sum:16'h0005, cnt:1, ovf:1'b0};
    frames[1] = '{n:3, b:32'h0080_01FF, sum:16'h0180, cnt:3, ovf:1'b0};
    frames[2] = '{n:2, b:32'h0000_8080, sum:16'h0100, cnt:2, ovf:1'b0};
    frames[3] = '{n:4, b:32'hFFFF_FFFF, sum:16'h03FC, cnt:4, ovf:1'b0};
    frames[4] = '{n:1, b:32'h0000_0000, sum:16'h0000, cnt:1, ovf:1'b0};
    frames[5] = '{n:2, b:32'h0000_907F, sum:16'h010F, cnt:2, ovf:1'b0};

    // Back-to-back frames {01,02} and {FE}; row k holds the inputs driven
    // after edge k and the outputs expected once edge k has occurred.
    steps[0]  = '{iv:1, d:8'h01, l:0, rdy:1, ov:0, a:8'h00, b:8'h00, sum:16'h0000, cnt:0};
    steps[1]  = '{iv:1, d:8'h02, l:1, rdy:0, ov:0, a:8'h00, b:8'h01, sum:16'h0000, cnt:0};
    steps[2]  = '{iv:1, d:8'h02, l:1, rdy:0, ov:0, a:8'h00, b:8'h00, sum:16'h0001, cnt:0};
    steps[3]  = '{iv:1, d:8'h02, l:1, rdy:1, ov:0, a:8'h00, b:8'h00, sum:16'h0001, cnt:1};
    steps[4]  = '{iv:1, d:8'hFE, l:1, rdy:0, ov:0, a:8'h01, b:8'h02, sum:16'h0001, cnt:1};
    steps[5]  = '{iv:1, d:8'hFE, l:1, rdy:0, ov:0, a:8'h00, b:8'h00, sum:16'h0003, cnt:1};
    steps[6]  = '{iv:1, d:8'hFE, l:1, rdy:0, ov:1, a:8'h00, b:8'h00, sum:16'h0003, cnt:2};
    steps[7]  = '{iv:1, d:8'hFE, l:1, rdy:1, ov:0, a:8'h00, b:8'h00, sum:16'h0000, cnt:0};
    steps[8]  = '{iv:0, d:8'h00, l:0, rdy:0, ov:0, a:8'h00, b:8'hFE, sum:16'h0000, cnt:0};
    steps[9]  = '{iv:0, d:8'h00, l:0, rdy:0, ov:0, a:8'h00, b:8'h00, sum:16'h00FE, cnt:0};
    steps[10] = '{iv:0, d:8'h00, l:0, rdy:0, ov:1, a:8'h00, b:8'h00, sum:16'h00FE, cnt:1};
    steps[11] = '{iv:0, d:8'h00, l:0, rdy:1, ov:0, a:8'h00, b:8'h00, sum:16'h0000, cnt:0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #3;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Cycle-exact back-to-back sequence straight out of reset.
    @(posedge clk); #1;
    for (int r = 0; r < 12; r++) begin
      in_valid = steps[r].iv;
      in_data  = steps[r].d;
      in_last  = steps[r].l;
      @(negedge clk);
      check($sformatf("b2b[%0d]_in_ready", r),  32'(in_ready),  32'(steps[r].rdy));
      check($sformatf("b2b[%0d]_out_valid", r), 32'(out_valid), 32'(steps[r].ov));
      check($sformatf("b2b[%0d]_add_a", r),     32'(add_a),     32'(steps[r].a));
      check($sformatf("b2b[%0d]_add_b", r),     32'(add_b),     32'(steps[r].b));
      check($sformatf("b2b[%0d]_out_sum", r),   32'(out_sum),   32'(steps[r].sum));
      check($sformatf("b2b[%0d]_out_count", r), 32'(out_count), 32'(steps[r].cnt));
      @(posedge clk); #1;
    end

    // Frame table, consumer always ready.
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < frames[f].n; i++)
        send_byte(frames[f].b[i], (i == frames[f].n - 1));
      wait_result(waited);
      check($sformatf("frame%0d_latency_ok", f), 32'(waited >= 2 && waited <= 3), 32'd1);
      check($sformatf("frame%0d_out_sum", f),    32'(out_sum),   32'(frames[f].sum));
      check($sformatf("frame%0d_out_count", f),  32'(out_count), 32'(frames[f].cnt));
      check($sformatf("frame%0d_out_ovf", f),    32'(out_ovf),   32'(frames[f].ovf));
      @(posedge clk); #1;
      check($sformatf("frame%0d_in_ready_after", f),  32'(in_ready),  32'd1);
      check($sformatf("frame%0d_out_valid_after", f), 32'(out_valid), 32'd0);
    end

    // 258 bytes of 0xFF: count saturates, high-pass carry sets overflow.
    for (int i = 0; i < 257; i++) send_byte(8'hFF, 1'b0);
    waited = 0;
    while (!in_ready && waited < 10) begin
      @(posedge clk); #1;
      waited++;
    end
    check("sat257_out_sum",   32'(out_sum),   32'h0000_FFFF);
    check("sat257_out_ovf",   32'(out_ovf),   32'd0);
    check("sat257_out_count", 32'(out_count), 32'd255);
    send_byte(8'hFF, 1'b1);
    wait_result(waited);
    check("sat258_out_sum",   32'(out_sum),   32'h0000_00FE);
    check("sat258_out_ovf",   32'(out_ovf),   32'd1);
    check("sat258_out_count", 32'(out_count), 32'd255);
    @(posedge clk); #1;

    // Back-pressure: result held, new byte blocked until the handshake.
    out_ready = 1'b0;
    send_byte(8'h10, 1'b1);
    wait_result(waited);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = 8'h33;
    in_last  = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("stall%0d_in_ready", c),  32'(in_ready),  32'd0);
      check($sformatf("stall%0d_out_valid", c), 32'(out_valid), 32'd1);
      check($sformatf("stall%0d_out_sum", c),   32'(out_sum),   32'h0000_0010);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_result(waited);
    check("after_stall_out_sum",   32'(out_sum),   32'h0000_0033);
    check("after_stall_out_count", 32'(out_count), 32'd1);
    check("after_stall_out_ovf",   32'(out_ovf),   32'd0);

    // Reset during the high pass of 0x7F + 0x90 (low pass carries out).
    send_byte(8'h7F, 1'b0);
    send_byte(8'h90, 1'b1);
    @(posedge clk); #1;
    check("midframe_add_b_carry", 32'(add_b),   32'd1);
    check("midframe_out_sum",     32'(out_sum), 32'h0000_000F);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_byte(8'h10, 1'b1);
    wait_result(waited);
    check("post_reset_out_sum",   32'(out_sum),   32'h0000_0010);
    check("post_reset_out_count", 32'(out_count), 32'd1);
    check("post_reset_out_ovf",   32'(out_ovf),   32'd0);
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
